// File: rtl/pick_voq.sv
// pick_voq: round-robin VOQ selector for one ingress port of the crossbar
// scheduler. Returns the first VOQ that is non-empty and whose egress is not
// yet claimed, searching circularly from start_voq_num.
//
// Ports:
//   clk, reset        clock / synchronous active-high reset (registered build only)
//   start_voq_num     highest-priority VOQ index for this search
//   voq_empty         bit k = 1: VOQ k holds no packet
//   voq_picked        bit k = 1: egress k already taken this pass
//   no_available_voq  1 when no VOQ is eligible
//   voq_to_pick       selected VOQ index (start_voq_num when none eligible)
//
// Configuration macro: PICK_VOQ_REG_OUT_EN
//   defined   -> outputs registered, 1-cycle latency, reset values 1 / 0
//   undefined -> purely combinational, clk and reset ignored
module pick_voq #(
  parameter int unsigned  NUM_VOQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_VOQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   start_voq_num,
  input  logic [NUM_VOQ-1:0] voq_empty,
  input  logic [NUM_VOQ-1:0] voq_picked,
  output logic               no_available_voq,
  output logic [IDX_W-1:0]   voq_to_pick
);

  logic [NUM_VOQ-1:0] eligible_c;
  logic [NUM_VOQ-1:0] rotated_c;
  logic [IDX_W-1:0]   offset_c;
  logic [IDX_W-1:0]   pick_c;
  logic               none_c;

  // Rotate eligibility right by the start pointer so bit 0 is the top priority.
  always_comb begin
    logic [IDX_W-1:0] src;
    src        = '0;
    eligible_c = ~voq_empty & ~voq_picked;
    rotated_c  = '0;
    for (int i = 0; i < NUM_VOQ; i++) begin
      src          = IDX_W'(i) + start_voq_num;  // wraps by truncation
      rotated_c[i] = eligible_c[src];
    end
  end

  // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
  always_comb begin
    offset_c = '0;
    for (int i = NUM_VOQ - 1; i >= 0; i--) begin
      if (rotated_c[i]) offset_c = IDX_W'(i);
    end
  end

  // Offset is zero when nothing is eligible, so the pick falls back to start.
  always_comb begin
    none_c = ~|eligible_c;
    pick_c = start_voq_num + offset_c;
  end

`ifdef PICK_VOQ_REG_OUT_EN
  // Output register stage; reset wins over the input sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      no_available_voq <= 1'b1;
      voq_to_pick      <= '0;
    end else begin
      no_available_voq <= none_c;
      voq_to_pick      <= pick_c;
    end
  end
`else
  // Combinational build: clock and reset are intentionally unused.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign no_available_voq = none_c;
  assign voq_to_pick      = pick_c;
`endif

endmodule

// File: tb/tb_pick_voq.sv
// tb_pick_voq: directed and swept checks of pick_voq for NUM_VOQ=4 and 8,
// against a plain circular-search reference. Covers the registered build
// (reset values, latency, mid-stream reset) when PICK_VOQ_REG_OUT_EN is set.
module tb_pick_voq;

  logic       clk;
  logic       reset;
  logic [1:0] start4;
  logic [3:0] empty4, picked4;
  logic       none4;
  logic [1:0] pick4;
  logic [2:0] start8;
  logic [7:0] empty8, picked8;
  logic       none8;
  logic [2:0] pick8;

  int unsigned n_checks;
  int unsigned n_fail;

  pick_voq #(.NUM_VOQ(4)) dut4 (
    .clk(clk), .reset(reset), .start_voq_num(start4), .voq_empty(empty4),
    .voq_picked(picked4), .no_available_voq(none4), .voq_to_pick(pick4)
  );

  pick_voq #(.NUM_VOQ(8)) dut8 (
    .clk(clk), .reset(reset), .start_voq_num(start8), .voq_empty(empty8),
    .voq_picked(picked8), .no_available_voq(none8), .voq_to_pick(pick8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk (start + i) mod n and return the first eligible index, -1 if none.
  function automatic int ref_search(input int n, input int start,
                                    input logic [7:0] emp, input logic [7:0] pk);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = (start + i) % n;
      if (!emp[idx] && !pk[idx]) return idx;
    end
    return -1;
  endfunction

  // Wait until outputs reflect the current inputs.
  task automatic settle();
`ifdef PICK_VOQ_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic drive4(input logic [1:0] s, input logic [3:0] e, input logic [3:0] p);
    start4  = s;
    empty4  = e;
    picked4 = p;
  endtask

  task automatic check4(input string tag);
    int r;
    r = ref_search(4, int'(start4), {4'b0, empty4}, {4'b0, picked4});
    check({tag, ".none"}, 32'(none4), (r < 0) ? 32'd1 : 32'd0);
    check({tag, ".pick"}, 32'(pick4), (r < 0) ? 32'(start4) : 32'(r));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive4(2'd0, 4'b1111, 4'b0000);
    start8   = '0;
    empty8   = '1;
    picked8  = '0;

`ifdef PICK_VOQ_REG_OUT_EN
    repeat (2) @(posedge clk);
    #1;
    check("rst.none", 32'(none4), 32'd1);
    check("rst.pick", 32'(pick4), 32'd0);
    check("rst8.none", 32'(none8), 32'd1);
    check("rst8.pick", 32'(pick8), 32'd0);
    reset = 1'b0;
    settle();
    check("idle.none", 32'(none4), 32'd1);
    check("idle.pick", 32'(pick4), 32'd0);
    drive4(2'd1, 4'b0001, 4'b0000);
    #1;
    check("lat0.none", 32'(none4), 32'd1);
    check("lat0.pick", 32'(pick4), 32'd0);
    settle();
    check("lat1.none", 32'(none4), 32'd0);
    check("lat1.pick", 32'(pick4), 32'd1);
`else
    #1;
    reset = 1'b0;
`endif

    // Directed vectors with hand-computed results.
    drive4(2'd0, 4'b0000, 4'b0000);
    settle();
    check("d0.none", 32'(none4), 32'd0);
    check("d0.pick", 32'(pick4), 32'd0);

    drive4(2'd2, 4'b0100, 4'b1000);
    settle();
    check("wrap.none", 32'(none4), 32'd0);
    check("wrap.pick", 32'(pick4), 32'd0);

    drive4(2'd3, 4'b0110, 4'b1001);
    settle();
    check("full.none", 32'(none4), 32'd1);
    check("full.pick", 32'(pick4), 32'd3);

    drive4(2'd1, 4'b1111, 4'b0000);
    settle();
    check("allemp.none", 32'(none4), 32'd1);
    drive4(2'd1, 4'b1101, 4'b0000);
    settle();
    check("drop.none", 32'(none4), 32'd0);
    check("drop.pick", 32'(pick4), 32'd1);

    drive4(2'd3, 4'b0000, 4'b1000);
    settle();
    check("skip3.pick", 32'(pick4), 32'd0);

    // Exhaustive sweep for NUM_VOQ=4.
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < 16; e++) begin
        for (int p = 0; p < 16; p++) begin
          drive4(2'(s), 4'(e), 4'(p));
          settle();
          check4("sweep4");
        end
      end
    end

    // Random vectors for NUM_VOQ=8, biased towards sparse eligibility.
    for (int n = 0; n < 400; n++) begin
      int r;
      start8  = 3'($urandom_range(0, 7));
      empty8  = 8'($urandom) | 8'($urandom);
      picked8 = 8'($urandom) & 8'($urandom_range(0, 255));
      settle();
      r = ref_search(8, int'(start8), empty8, picked8);
      check("rand8.none", 32'(none8), (r < 0) ? 32'd1 : 32'd0);
      check("rand8.pick", 32'(pick8), (r < 0) ? 32'(start8) : 32'(r));
    end

    // Boundaries for NUM_VOQ=8: last-index wrap and single eligible behind start.
    start8 = 3'd7; empty8 = 8'b1111_1110; picked8 = 8'b0;
    settle();
    check("w8.none", 32'(none8), 32'd0);
    check("w8.pick", 32'(pick8), 32'd0);
    start8 = 3'd5; empty8 = 8'b0000_0000; picked8 = 8'b1110_1111;
    settle();
    check("b8.pick", 32'(pick8), 32'd4);

`ifdef PICK_VOQ_REG_OUT_EN
    // Mid-stream reset with eligible inputs present.
    drive4(2'd2, 4'b0000, 4'b0000);
    start8 = 3'd6; empty8 = 8'b0; picked8 = 8'b0;
    reset  = 1'b1;
    settle();
    check("midrst.none", 32'(none4), 32'd1);
    check("midrst.pick", 32'(pick4), 32'd0);
    check("midrst8.none", 32'(none8), 32'd1);
    check("midrst8.pick", 32'(pick8), 32'd0);
    reset = 1'b0;
    settle();
    check("post.pick", 32'(pick4), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
